// File: rtl/odbiornik_rx_if.sv
// Serial-line and byte-bus bundle for odbiornik_rx; parity_err exists only with RX_PARITY_EN.
// Master is the receiver (drives the byte side); slave is the line driver / byte consumer.
interface odbiornik_rx_if;
    logic       rx_i;
    logic [7:0] data_rx;
    logic       trans;
    logic       frame_err;
    logic       busy;
`ifdef RX_PARITY_EN
    logic       parity_err;

    modport master (
        input  rx_i,
        output data_rx,
        output trans,
        output frame_err,
        output busy,
        output parity_err
    );

    modport slave (
        output rx_i,
        input  data_rx,
        input  trans,
        input  frame_err,
        input  busy,
        input  parity_err
    );
`else
    modport master (
        input  rx_i,
        output data_rx,
        output trans,
        output frame_err,
        output busy
    );

    modport slave (
        output rx_i,
        input  data_rx,
        input  trans,
        input  frame_err,
        input  busy
    );
`endif
endinterface

// File: rtl/odbiornik_rx.sv
// UART receiver, 8N1 LSB first (8E1 with RX_PARITY_EN); trans 2+HALF_BIT+9*CLKS_PER_BIT+1 clk after start edge.
// No backpressure: every good frame overwrites data_rx; a held-low line yields one frame_err.
module odbiornik_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    odbiornik_rx_if.master       bus
);

    localparam int          HALF_BIT    = CLKS_PER_BIT / 2;
    localparam logic [15:0] C_HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] C_BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_trans;
    logic        r_ferr;

    logic        w_rx_s;
    logic        w_bit_end;

    assign w_rx_s    = r_sync2;
    assign w_bit_end = (r_baud == C_BIT_LAST);

`ifdef RX_PARITY_EN
    logic        r_par_bit;
    logic        r_perr;
    logic        w_par_bad;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_par_bad = ^{r_shift, r_par_bit};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_baud    <= 16'd0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_trans   <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef RX_PARITY_EN
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_sync1 <= bus.rx_i;
            r_sync2 <= r_sync1;
            r_trans <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_baud <= 16'd0;
                    r_bit  <= 3'd0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    // A start bit that is high again at its mid-point was a glitch.
                    if (r_baud == C_HALF_LAST) begin
                        r_baud  <= 16'd0;
                        r_bit   <= 3'd0;
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud         <= 16'd0;
                        r_shift[r_bit] <= w_rx_s;
                        r_bit          <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
`ifdef RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= 16'd0;
`ifdef RX_PARITY_EN
                        r_par_bit <= w_rx_s;
`endif
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= 16'd0;
                        if (w_rx_s) begin
`ifdef RX_PARITY_EN
                            if (w_par_bad) begin
                                r_perr <= 1'b1;
                            end else begin
                                r_data  <= r_shift;
                                r_trans <= 1'b1;
                            end
`else
                            r_data  <= r_shift;
                            r_trans <= 1'b1;
`endif
                            r_state <= S_IDLE;
                        end else begin
                            // Low stop bit: report once, then wait out any break.
                            r_ferr  <= 1'b1;
`ifdef RX_PARITY_EN
                            r_perr  <= w_par_bad;
`endif
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end

                S_BREAK: begin
                    r_baud <= 16'd0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_rx    = r_data;
    assign bus.trans      = r_trans;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = (r_state != S_IDLE);
`ifdef RX_PARITY_EN
    assign bus.parity_err = r_perr;
`endif

endmodule

// File: tb/tb_odbiornik_rx.sv
// Directed bench for odbiornik_rx at CLKS_PER_BIT=16; RX_PARITY_EN adds the 8E1 cases.
// Frames are driven on the falling clock edge and outputs are sampled there as well.
module tb_odbiornik_rx;

    localparam int CPB = 16;
`ifdef RX_PARITY_EN
    localparam int LAT = 2 + CPB/2 + 10*CPB + 1;
`else
    localparam int LAT = 2 + CPB/2 + 9*CPB + 1;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    odbiornik_rx_if u_if();

    odbiornik_rx #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (u_if)
    );

    int n_cmp   = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_start = 0;
    int t_trans = 0;
    int n_trans = 0;
    int n_ferr  = 0;
    int n_both  = 0;
    int n_busy  = 0;
    logic [7:0] rx_q[$];
`ifdef RX_PARITY_EN
    int   n_perr   = 0;
    logic par_flip = 1'b0;
`endif

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (u_if.trans === 1'b1) begin
            n_trans = n_trans + 1;
            t_trans = cyc;
            rx_q.push_back(u_if.data_rx);
        end
        if (u_if.frame_err === 1'b1) n_ferr = n_ferr + 1;
        if (u_if.trans === 1'b1 && u_if.frame_err === 1'b1) n_both = n_both + 1;
        if (u_if.busy === 1'b1) n_busy = n_busy + 1;
`ifdef RX_PARITY_EN
        if (u_if.parity_err === 1'b1) n_perr = n_perr + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Leaves the line at the stop-bit level when done.
    task automatic send(input logic [7:0] b, input logic stop_val);
        u_if.rx_i = 1'b0;
        t_start   = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            u_if.rx_i = b[i];
            tick(CPB);
        end
`ifdef RX_PARITY_EN
        u_if.rx_i = (^b) ^ par_flip;
        tick(CPB);
`endif
        u_if.rx_i = stop_val;
        tick(CPB);
    endtask

    initial begin
        int b_tr;
        int b_fe;
        int b_bs;
        int b_q;
        int w;
        logic [7:0] v77;

        u_if.rx_i = 1'b1;
        rst_i     = 1'b1;
        tick(3);
        rst_i = 1'b0;
        tick(1);
        check("rst_data_rx",   u_if.data_rx,   8'h00);
        check("rst_trans",     u_if.trans,     1'b0);
        check("rst_frame_err", u_if.frame_err, 1'b0);
        check("rst_busy",      u_if.busy,      1'b0);
`ifdef RX_PARITY_EN
        check("rst_parity_err", u_if.parity_err, 1'b0);
`endif
        tick(4);

        // Single frame, exact timing.
        b_tr = n_trans; b_fe = n_ferr;
        send(8'h41, 1'b1);
        tick(4);
        check("t41_trans_count", n_trans - b_tr, 1);
        check("t41_data_rx",     u_if.data_rx,   8'h41);
        check("t41_frame_err",   n_ferr - b_fe,  0);
        check("t41_busy_after",  u_if.busy,      1'b0);
        check("t41_latency_win",
              ((t_trans - t_start) >= LAT - 1) && ((t_trans - t_start) <= LAT + 1), 1'b1);

        // Back-to-back frames with no idle gap.
        b_tr = n_trans; b_q = rx_q.size();
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        tick(4);
        check("b2b_trans_count", n_trans - b_tr, 2);
        check("b2b_queue_len",   rx_q.size() - b_q, 2);
        if (rx_q.size() >= b_q + 2) begin
            check("b2b_first",  rx_q[b_q],     8'h00);
            check("b2b_second", rx_q[b_q + 1], 8'hFF);
        end
        check("b2b_data_rx", u_if.data_rx, 8'hFF);

        // Short low glitch on an idle line.
        b_tr = n_trans; b_fe = n_ferr; b_bs = n_busy;
        u_if.rx_i = 1'b0;
        tick(5);
        u_if.rx_i = 1'b1;
        tick(20);
        check("glitch_busy_len", ((n_busy - b_bs) > 0) && ((n_busy - b_bs) <= 11), 1'b1);
        check("glitch_no_trans", n_trans - b_tr, 0);
        check("glitch_no_ferr",  n_ferr - b_fe,  0);
        check("glitch_idle",     u_if.busy,      1'b0);
        b_tr = n_trans;
        send(8'h5A, 1'b1);
        tick(4);
        check("after_glitch_trans", n_trans - b_tr, 1);
        check("after_glitch_data",  u_if.data_rx,   8'h5A);

        // Low stop bit followed by a held break.
        b_tr = n_trans; b_fe = n_ferr;
        send(8'h3C, 1'b0);
        tick(100);
        check("break_busy_held", u_if.busy,     1'b1);
        check("break_one_ferr",  n_ferr - b_fe, 1);
        u_if.rx_i = 1'b1;
        w = 0;
        while (u_if.busy === 1'b1 && w < 10) begin
            tick(1);
            w = w + 1;
        end
        check("break_busy_falls", u_if.busy,      1'b0);
        check("break_no_trans",   n_trans - b_tr, 0);
        check("break_data_kept",  u_if.data_rx,   8'h5A);
        tick(4);
        check("break_ferr_total", n_ferr - b_fe,  1);

        // Reset in the middle of data bit 4.
        b_tr = n_trans;
        v77  = 8'h77;
        u_if.rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            u_if.rx_i = v77[i];
            tick(CPB);
        end
        u_if.rx_i = v77[4];
        tick(CPB/2);
        rst_i = 1'b1;
        tick(1);
        check("midrst_data_rx",   u_if.data_rx,   8'h00);
        check("midrst_trans",     u_if.trans,     1'b0);
        check("midrst_frame_err", u_if.frame_err, 1'b0);
        check("midrst_busy",      u_if.busy,      1'b0);
        rst_i     = 1'b0;
        u_if.rx_i = 1'b1;
        tick(CPB * 12);
        check("midrst_no_trans", n_trans - b_tr, 0);
        b_tr = n_trans;
        send(8'h12, 1'b1);
        tick(4);
        check("midrst_next_trans", n_trans - b_tr, 1);
        check("midrst_next_data",  u_if.data_rx,   8'h12);

`ifdef RX_PARITY_EN
        b_tr = n_trans; b_fe = n_perr;
        par_flip = 1'b0;
        send(8'h41, 1'b1);
        tick(4);
        check("par_ok_trans", n_trans - b_tr, 1);
        check("par_ok_data",  u_if.data_rx,   8'h41);
        check("par_ok_perr",  n_perr - b_fe,  0);
        b_tr = n_trans; b_fe = n_perr;
        par_flip = 1'b1;
        send(8'h41, 1'b1);
        tick(4);
        par_flip = 1'b0;
        check("par_bad_perr",  n_perr - b_fe,  1);
        check("par_bad_trans", n_trans - b_tr, 0);
        check("par_bad_data",  u_if.data_rx,   8'h41);
`endif

        check("strobes_never_overlap", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
